// File: rtl/fp_mul_result_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mul_result_checker_pkg : shared tags, FP32 constants and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package fp_mul_result_checker_pkg;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_A    = 2'b01;
  localparam logic [1:0] TAG_B    = 2'b10;
  localparam logic [1:0] TAG_ILL  = 2'b11;

  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_CMP    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fp_mul_result_checker_fp32_classify.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp32_classify : combinational IEEE-754 single-precision NaN/Inf/zero flags
// Rev 1.0
// ---------------------------------------------------------------------------
module fp32_classify
  import fp_mul_result_checker_pkg::*;
(
  input  logic [31:0] in_val,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  logic [7:0]  exp_f;
  logic [22:0] mant_f;
  logic        unused_sign;

  assign exp_f       = in_val[30:23];
  assign mant_f      = in_val[22:0];
  // Sign never affects the class; signed-zero/NaN handling lives in the comparator.
  assign unused_sign = in_val[31];

  assign is_nan  = (exp_f == FP32_EXP_MAX) && (mant_f != '0);
  assign is_inf  = (exp_f == FP32_EXP_MAX) && (mant_f == '0);
  assign is_zero = (exp_f == '0) && (mant_f == '0);

endmodule
`default_nettype wire

// File: rtl/fp_mul_result_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mul_result_checker : pairs lane-A/lane-B multiplier results, compares them
// IEEE-754-aware and keeps pass/fail counters plus sticky error flags. Rev 1.0
// ---------------------------------------------------------------------------
module fp_mul_result_checker
  import fp_mul_result_checker_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 64,
  parameter int NAN_EQUIV  = 1,
  parameter int ZERO_EQUIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_res,
  input  logic [1:0]       in_tag,
  input  logic             clr,
  output logic             cmp_valid,
  output logic             cmp_match,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_dup,
  output logic             err_tag,
  output logic             err_timeout
);

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       tag_q;
  logic [31:0]      cap_a_q, cap_a_d;
  logic [31:0]      cap_b_q, cap_b_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             cmp_match_q, cmp_match_d;
  logic [31:0]      cmp_a_q, cmp_a_d;
  logic [31:0]      cmp_b_q, cmp_b_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_dup_q, err_dup_d;
  logic             err_tag_q, err_tag_d;
  logic             err_timeout_q, err_timeout_d;

  logic evt_a, evt_b;
  logic pass_inc, fail_inc, dup_set, tmo_set;
  logic nan_a, inf_a, zero_a;
  logic nan_b, inf_b, zero_b;
  logic match;

  // A tag only counts on its first cycle; a held tag is the same result.
  assign evt_a = (in_tag == TAG_A) && (in_tag != tag_q);
  assign evt_b = (in_tag == TAG_B) && (in_tag != tag_q);

  fp32_classify u_class_a (
    .in_val  (cap_a_q),
    .is_nan  (nan_a),
    .is_inf  (inf_a),
    .is_zero (zero_a)
  );

  fp32_classify u_class_b (
    .in_val  (cap_b_q),
    .is_nan  (nan_b),
    .is_inf  (inf_b),
    .is_zero (zero_b)
  );

  // Infinities are never folded into an equivalence class: only bitwise equality.
  always_comb begin
    match = (cap_a_q == cap_b_q);
    if (!(inf_a || inf_b)) begin
      if ((NAN_EQUIV != 0) && nan_a && nan_b) begin
        match = 1'b1;
      end
      if ((ZERO_EQUIV != 0) && zero_a && zero_b) begin
        match = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    tmo_d       = tmo_q;
    cmp_valid_d = 1'b0;
    cmp_match_d = cmp_match_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    pass_inc    = 1'b0;
    fail_inc    = 1'b0;
    dup_set     = 1'b0;
    tmo_set     = 1'b0;

    case (state_q)
      ST_IDLE, ST_CMP: begin
        if (state_q == ST_CMP) begin
          cmp_valid_d = 1'b1;
          cmp_match_d = match;
          cmp_a_d     = cap_a_q;
          cmp_b_d     = cap_b_q;
          pass_inc    = match;
          fail_inc    = !match;
        end
        tmo_d = '0;
        if (evt_a) begin
          cap_a_d = in_res;
          state_d = ST_WAIT_B;
        end else if (evt_b) begin
          cap_b_d = in_res;
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_A, ST_WAIT_B: begin
        if ((state_q == ST_WAIT_B && evt_b) || (state_q == ST_WAIT_A && evt_a)) begin
          if (evt_a) cap_a_d = in_res;
          else       cap_b_d = in_res;
          tmo_d   = '0;
          state_d = ST_CMP;
        end else if (evt_a || evt_b) begin
          if (evt_a) cap_a_d = in_res;
          else       cap_b_d = in_res;
          dup_set = 1'b1;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Counter would reach TIMEOUT now: report the lone value, missing lane as 0.
          cmp_valid_d = 1'b1;
          cmp_match_d = 1'b0;
          cmp_a_d     = (state_q == ST_WAIT_B) ? cap_a_q : 32'h0;
          cmp_b_d     = (state_q == ST_WAIT_A) ? cap_b_q : 32'h0;
          fail_inc    = 1'b1;
          tmo_set     = 1'b1;
          tmo_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end
    endcase
  end

  // Statistics: clear has priority over any increment or flag set.
  always_comb begin
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    err_dup_d     = err_dup_q | dup_set;
    err_tag_d     = err_tag_q | (in_tag == TAG_ILL);
    err_timeout_d = err_timeout_q | tmo_set;
    if (pass_inc && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
    if (fail_inc && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
    if (clr) begin
      pass_cnt_d    = '0;
      fail_cnt_d    = '0;
      err_dup_d     = 1'b0;
      err_tag_d     = 1'b0;
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tag_q         <= TAG_NONE;
      cap_a_q       <= '0;
      cap_b_q       <= '0;
      tmo_q         <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_match_q   <= 1'b0;
      cmp_a_q       <= '0;
      cmp_b_q       <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      err_dup_q     <= 1'b0;
      err_tag_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tag_q         <= in_tag;
      cap_a_q       <= cap_a_d;
      cap_b_q       <= cap_b_d;
      tmo_q         <= tmo_d;
      cmp_valid_q   <= cmp_valid_d;
      cmp_match_q   <= cmp_match_d;
      cmp_a_q       <= cmp_a_d;
      cmp_b_q       <= cmp_b_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      err_dup_q     <= err_dup_d;
      err_tag_q     <= err_tag_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cmp_valid   = cmp_valid_q;
  assign cmp_match   = cmp_match_q;
  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign err_dup     = err_dup_q;
  assign err_tag     = err_tag_q;
  assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_result_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_mul_result_checker : directed vector table plus hand-written corner
// sequences for fp_mul_result_checker. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fp_mul_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_res = '0;
  logic [1:0]  in_tag = 2'b00;
  logic        clr = 1'b0;
  logic        cmp_valid, cmp_match, err_dup, err_tag, err_timeout;
  logic [31:0] cmp_a, cmp_b;
  logic [15:0] pass_cnt, fail_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  always #5 clk = ~clk;

  fp_mul_result_checker #(
    .CNT_W(16), .TIMEOUT(64), .NAN_EQUIV(1), .ZERO_EQUIV(1)
  ) dut (
    .clk(clk), .rst(rst), .in_res(in_res), .in_tag(in_tag), .clr(clr),
    .cmp_valid(cmp_valid), .cmp_match(cmp_match), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_dup(err_dup),
    .err_tag(err_tag), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          b_first;
    int          gap;
    bit          exp_match;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of input from the falling edge.
  task automatic send(input logic [1:0] tag, input logic [31:0] res);
    @(negedge clk);
    in_tag = tag;
    in_res = res;
  endtask

  // Call right after the second lane was driven: verdict must appear exactly two edges later.
  task automatic expect_verdict(input string name, input bit m,
                                input logic [31:0] a, input logic [31:0] b);
    send(2'b00, 32'h0);
    chk({name, " early valid"}, {31'b0, cmp_valid}, 32'd0);
    @(negedge clk);
    if (m) exp_pass++;
    else   exp_fail++;
    chk({name, " valid"}, {31'b0, cmp_valid}, 32'd1);
    chk({name, " match"}, {31'b0, cmp_match}, {31'b0, m});
    chk({name, " cmp_a"}, cmp_a, a);
    chk({name, " cmp_b"}, cmp_b, b);
    chk({name, " pass_cnt"}, {16'b0, pass_cnt}, exp_pass);
    chk({name, " fail_cnt"}, {16'b0, fail_cnt}, exp_fail);
    @(negedge clk);
    chk({name, " pulse width"}, {31'b0, cmp_valid}, 32'd0);
  endtask

  initial begin
    int n_valid;
    int first_at;

    vecs[0] = '{32'h40C00000, 32'h40C00000, 1'b0, 3, 1'b1};
    vecs[1] = '{32'h40C00001, 32'h40C00000, 1'b1, 0, 1'b0};
    vecs[2] = '{32'h7FC00000, 32'hFFC00001, 1'b0, 1, 1'b1};
    vecs[3] = '{32'h00000000, 32'h80000000, 1'b0, 0, 1'b1};
    vecs[4] = '{32'h7F800000, 32'hFF800000, 1'b1, 2, 1'b0};
    vecs[5] = '{32'h7F800000, 32'h7F800000, 1'b0, 0, 1'b1};
    vecs[6] = '{32'h7FC00000, 32'h7F800000, 1'b0, 0, 1'b0};
    vecs[7] = '{32'h3F800000, 32'hBF800000, 1'b1, 1, 1'b0};
    vecs[8] = '{32'h00000001, 32'h80000001, 1'b0, 0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset cmp_valid", {31'b0, cmp_valid}, 32'd0);
    chk("reset cmp_match", {31'b0, cmp_match}, 32'd0);
    chk("reset cmp_a", cmp_a, 32'd0);
    chk("reset cmp_b", cmp_b, 32'd0);
    chk("reset counters", {pass_cnt, fail_cnt}, 32'd0);
    chk("reset flags", {29'b0, err_dup, err_tag, err_timeout}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].b_first ? 2'b10 : 2'b01, vecs[i].b_first ? vecs[i].b : vecs[i].a);
      for (int g = 0; g < vecs[i].gap; g++) send(2'b00, 32'h0);
      send(vecs[i].b_first ? 2'b01 : 2'b10, vecs[i].b_first ? vecs[i].a : vecs[i].b);
      expect_verdict($sformatf("vec%0d", i), vecs[i].exp_match, vecs[i].a, vecs[i].b);
    end

    // Next pair starts while the previous one is in its compare cycle.
    send(2'b01, 32'h40000000);
    send(2'b10, 32'h40000000);
    send(2'b01, 32'h40400000);
    chk("b2b early valid", {31'b0, cmp_valid}, 32'd0);
    send(2'b10, 32'h40400001);
    exp_pass++;
    chk("b2b first valid", {31'b0, cmp_valid}, 32'd1);
    chk("b2b first match", {31'b0, cmp_match}, 32'd1);
    chk("b2b first cmp_a", cmp_a, 32'h40000000);
    expect_verdict("b2b second", 1'b0, 32'h40400000, 32'h40400001);

    // Duplicate lane A, then illegal tag.
    send(2'b01, 32'h3F800000);
    send(2'b00, 32'h0);
    send(2'b01, 32'h40000000);
    send(2'b00, 32'h0);
    send(2'b10, 32'h40000000);
    expect_verdict("dup", 1'b1, 32'h40000000, 32'h40000000);
    chk("err_dup", {31'b0, err_dup}, 32'd1);
    chk("err_tag before", {31'b0, err_tag}, 32'd0);
    send(2'b11, 32'h12345678);
    send(2'b00, 32'h0);
    chk("err_tag", {31'b0, err_tag}, 32'd1);
    chk("tag11 no verdict", {31'b0, cmp_valid}, 32'd0);

    // Lone lane A held for 100 cycles: one timeout verdict, 64 cycles after capture.
    send(2'b01, 32'h3F800000);
    n_valid  = 0;
    first_at = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (cmp_valid) begin
        n_valid++;
        if (first_at < 0) begin
          first_at = i;
          chk("timeout match", {31'b0, cmp_match}, 32'd0);
          chk("timeout cmp_a", cmp_a, 32'h3F800000);
          chk("timeout cmp_b", cmp_b, 32'h0);
        end
      end
    end
    exp_fail++;
    chk("timeout verdict count", n_valid, 32'd1);
    chk("timeout verdict cycle", first_at, 32'd65);
    chk("err_timeout", {31'b0, err_timeout}, 32'd1);
    chk("timeout fail_cnt", {16'b0, fail_cnt}, exp_fail);
    chk("timeout pass_cnt", {16'b0, pass_cnt}, exp_pass);

    // Clear counters and sticky flags.
    send(2'b00, 32'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    chk("clr counters", {pass_cnt, fail_cnt}, 32'd0);
    chk("clr flags", {29'b0, err_dup, err_tag, err_timeout}, 32'd0);
    chk("clr keeps cmp_a", cmp_a, 32'h3F800000);

    // Second lane exactly at the deadline edge: pairing wins.
    send(2'b01, 32'h41200000);
    for (int j = 1; j <= 63; j++) send(2'b00, 32'h0);
    send(2'b10, 32'h41200000);
    expect_verdict("deadline", 1'b1, 32'h41200000, 32'h41200000);
    chk("deadline no timeout", {31'b0, err_timeout}, 32'd0);

    // Reset in WAIT_B: asynchronous, pair discarded.
    send(2'b01, 32'h40800000);
    send(2'b00, 32'h0);
    send(2'b00, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("midrst cmp_a", cmp_a, 32'h0);
    chk("midrst cmp_b", cmp_b, 32'h0);
    chk("midrst counters", {pass_cnt, fail_cnt}, 32'd0);
    chk("midrst outs", {28'b0, cmp_valid, cmp_match, err_dup, err_timeout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    n_valid = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (cmp_valid) n_valid++;
    end
    chk("midrst no verdict", n_valid, 32'd0);
    chk("midrst no timeout", {31'b0, err_timeout}, 32'd0);

    // clr on the same edge as a pass increment: clear wins, verdict still fires.
    send(2'b01, 32'h40A00000);
    send(2'b10, 32'h40A00000);
    @(negedge clk);
    in_tag = 2'b00;
    clr    = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr+inc valid", {31'b0, cmp_valid}, 32'd1);
    chk("clr+inc match", {31'b0, cmp_match}, 32'd1);
    chk("clr+inc pass_cnt", {16'b0, pass_cnt}, 32'd0);
    chk("clr+inc fail_cnt", {16'b0, fail_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
